// File: rtl/parking_counter_if.sv
// Purpose : bundles the pulse inputs and occupancy outputs of parking_counter.
// Latency : n/a (wiring only).
// Backpressure: none; the counter always accepts the entry/exit pulses.
//
// Port summary:
//   E, S, clr        - entry pulse, exit pulse, synchronous clear (master -> slave)
//   count, free      - cars inside / free spaces, binary, CW bits (slave -> master)
//   bcd_tens/units   - decimal digits of count (slave -> master)
//   full, empty      - decoded from the registered count (slave -> master)
//   upd              - one-cycle strobe after count changed (slave -> master)
//   err_over/under   - sticky overflow / underflow flags (slave -> master)
interface parking_counter_if #(
    parameter int CW = 7
) ();
    logic          E;
    logic          S;
    logic          clr;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic [3:0]    bcd_tens;
    logic [3:0]    bcd_units;
    logic          full;
    logic          empty;
    logic          upd;
    logic          err_over;
    logic          err_under;

    // Upstream side: direction FSM plus control, consumes the occupancy view.
    modport master (
        output E, S, clr,
        input  count, free, bcd_tens, bcd_units, full, empty, upd, err_over, err_under
    );

    // Counter side.
    modport slave (
        input  E, S, clr,
        output count, free, bcd_tens, bcd_units, full, empty, upd, err_over, err_under
    );
endinterface

// File: rtl/parking_counter.sv
// Purpose : parking-lot occupancy counter with BCD digits, full/empty/free and sticky errors.
// Latency : edge sampled at clock n is reflected on all outputs from cycle n+1; upd high in n+1 only.
// Backpressure: none; saturated events are dropped and flagged, simultaneous events cancel.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active low
//   bus  - parking_counter_if.slave (E, S, clr in; count, free, BCD, flags, upd, errors out)
module parking_counter #(
    parameter int CAPACITY = 20,
    parameter int CW       = 7
) (
    input  logic               clk,
    input  logic               rst,
    parking_counter_if.slave   bus
);

    localparam logic [CW-1:0] CAP = CW'(CAPACITY);

    // Previous samples of the pulse inputs for rising-edge detection.
    logic e_d;
    logic s_d;

    // Architectural state.
    logic [CW-1:0] count_q;
    logic [3:0]    tens_q;
    logic [3:0]    units_q;
    logic          upd_q;
    logic          err_over_q;
    logic          err_under_q;

    // Decoded per-cycle actions.
    logic e_ev;
    logic s_ev;
    logic do_inc;
    logic do_dec;
    logic set_over;
    logic set_under;

    // A level held high counts once: only the low-to-high transition is an event.
    assign e_ev = bus.E & ~e_d;
    assign s_ev = bus.S & ~s_d;

    // Priority: clr, then cancelling simultaneous events, then a single event.
    // Saturation is judged against the registered count, so no event can
    // push count past CAPACITY or below zero.
    always_comb begin
        do_inc    = 1'b0;
        do_dec    = 1'b0;
        set_over  = 1'b0;
        set_under = 1'b0;
        if (!bus.clr && (e_ev ^ s_ev)) begin
            if (e_ev) begin
                if (count_q < CAP) begin
                    do_inc = 1'b1;
                end else begin
                    set_over = 1'b1;
                end
            end else begin
                if (count_q != '0) begin
                    do_dec = 1'b1;
                end else begin
                    set_under = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_d         <= 1'b0;
            s_d         <= 1'b0;
            count_q     <= '0;
            tens_q      <= 4'd0;
            units_q     <= 4'd0;
            upd_q       <= 1'b0;
            err_over_q  <= 1'b0;
            err_under_q <= 1'b0;
        end else begin
            // Edge history always tracks the inputs, including during clr,
            // so a level that straddles clr is not counted afterwards.
            e_d   <= bus.E;
            s_d   <= bus.S;
            upd_q <= do_inc | do_dec;

            if (bus.clr) begin
                count_q     <= '0;
                tens_q      <= 4'd0;
                units_q     <= 4'd0;
                err_over_q  <= 1'b0;
                err_under_q <= 1'b0;
            end else begin
                if (do_inc) begin
                    count_q <= count_q + 1'b1;
                    // Units wrap 9->0 and carry into tens.
                    if (units_q == 4'd9) begin
                        units_q <= 4'd0;
                        tens_q  <= tens_q + 4'd1;
                    end else begin
                        units_q <= units_q + 4'd1;
                    end
                end

                if (do_dec) begin
                    count_q <= count_q - 1'b1;
                    // Units wrap 0->9 and borrow from tens.
                    if (units_q == 4'd0) begin
                        units_q <= 4'd9;
                        tens_q  <= tens_q - 4'd1;
                    end else begin
                        units_q <= units_q - 4'd1;
                    end
                end

                if (set_over) begin
                    err_over_q <= 1'b1;
                end
                if (set_under) begin
                    err_under_q <= 1'b1;
                end
            end
        end
    end

    // Flags and free space come from the registered count only, so nothing
    // on the input side has a combinational path to an output.
    assign bus.count     = count_q;
    assign bus.free      = CAP - count_q;
    assign bus.full      = (count_q == CAP);
    assign bus.empty     = (count_q == '0);
    assign bus.bcd_tens  = tens_q;
    assign bus.bcd_units = units_q;
    assign bus.upd       = upd_q;
    assign bus.err_over  = err_over_q;
    assign bus.err_under = err_under_q;

endmodule

// File: tb/tb_parking_counter.sv
// Purpose : directed self-checking bench for parking_counter (CAPACITY=20, CW=7).
// Latency : inputs driven 1 ns after the rising edge, outputs sampled 1 ns after the next one.
// Backpressure: n/a.
module tb_parking_counter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   upd_cnt;
    int   base;

    parking_counter_if #(.CW(7)) bus ();

    parking_counter #(.CAPACITY(20), .CW(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe counter and BCD invariant, evaluated every falling edge.
    always @(negedge clk) begin
        if (bus.upd === 1'b1) upd_cnt++;
        checks++;
        if ((int'(bus.bcd_tens) * 10 + int'(bus.bcd_units)) !== int'(bus.count)) begin
            errors++;
            $display("FAIL bcd_invariant t=%0t got %0d/%0d count %0d", $time,
                     bus.bcd_tens, bus.bcd_units, bus.count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_e();
        bus.E = 1'b1; tick();
        bus.E = 1'b0; tick();
    endtask

    task automatic pulse_s();
        bus.S = 1'b1; tick();
        bus.S = 1'b0; tick();
    endtask

    task automatic do_clr();
        bus.clr = 1'b1; tick();
        bus.clr = 1'b0; tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.E = 1'b0; bus.S = 1'b0; bus.clr = 1'b0;
        #3;
        checks++; if (bus.count !== 7'd0)  begin errors++; $display("FAIL rst_count got %0d exp 0", bus.count); end
        checks++; if (bus.free !== 7'd20)  begin errors++; $display("FAIL rst_free got %0d exp 20", bus.free); end
        checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL rst_flags empty=%b full=%b exp 1 0", bus.empty, bus.full); end
        checks++; if (bus.upd !== 1'b0 || bus.err_over !== 1'b0 || bus.err_under !== 1'b0) begin errors++; $display("FAIL rst_strobes upd=%b ov=%b un=%b exp 0 0 0", bus.upd, bus.err_over, bus.err_under); end
        checks++; if (bus.bcd_tens !== 4'd0 || bus.bcd_units !== 4'd0) begin errors++; $display("FAIL rst_bcd got %0d/%0d exp 0/0", bus.bcd_tens, bus.bcd_units); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        base = upd_cnt;
        for (int i = 1; i <= 3; i++) begin
            bus.E = 1'b1; tick();
            checks++; if (bus.upd !== 1'b1 || int'(bus.count) !== i) begin errors++; $display("FAIL basic_step%0d upd=%b count=%0d exp 1 %0d", i, bus.upd, bus.count, i); end
            bus.E = 1'b0; tick();
            checks++; if (bus.upd !== 1'b0) begin errors++; $display("FAIL basic_upd_low%0d got %b exp 0", i, bus.upd); end
        end
        checks++; if (bus.count !== 7'd3 || bus.free !== 7'd17) begin errors++; $display("FAIL basic_count count=%0d free=%0d exp 3 17", bus.count, bus.free); end
        checks++; if (bus.bcd_tens !== 4'd0 || bus.bcd_units !== 4'd3 || bus.empty !== 1'b0) begin errors++; $display("FAIL basic_bcd got %0d/%0d empty=%b exp 0/3 0", bus.bcd_tens, bus.bcd_units, bus.empty); end
        checks++; if (upd_cnt - base !== 3) begin errors++; $display("FAIL basic_upd_count got %0d exp 3", upd_cnt - base); end
    endtask

    task automatic test_bcd_carry();
        string pat;
        repeat (6) pulse_e();
        checks++; if (bus.bcd_tens !== 4'd0 || bus.bcd_units !== 4'd9) begin errors++; $display("FAIL bcd_at9 got %0d/%0d exp 0/9", bus.bcd_tens, bus.bcd_units); end
        pulse_e();
        checks++; if (bus.count !== 7'd10 || bus.bcd_tens !== 4'd1 || bus.bcd_units !== 4'd0) begin errors++; $display("FAIL bcd_carry count=%0d bcd=%0d/%0d exp 10 1/0", bus.count, bus.bcd_tens, bus.bcd_units); end
        pulse_s();
        checks++; if (bus.count !== 7'd9 || bus.bcd_tens !== 4'd0 || bus.bcd_units !== 4'd9) begin errors++; $display("FAIL bcd_borrow count=%0d bcd=%0d/%0d exp 9 0/9", bus.count, bus.bcd_tens, bus.bcd_units); end
        // 9 -> 10 11 12 11 12 13 12 11 12 13 14
        pat  = "EEESEESSEEE";
        base = upd_cnt;
        for (int i = 0; i < pat.len(); i++) begin
            if (pat[i] == "E") pulse_e(); else pulse_s();
        end
        checks++; if (bus.count !== 7'd14 || bus.bcd_tens !== 4'd1 || bus.bcd_units !== 4'd4) begin errors++; $display("FAIL bcd_mix count=%0d bcd=%0d/%0d exp 14 1/4", bus.count, bus.bcd_tens, bus.bcd_units); end
        checks++; if (upd_cnt - base !== 11) begin errors++; $display("FAIL bcd_mix_upd got %0d exp 11", upd_cnt - base); end
    endtask

    task automatic test_fill();
        bus.clr = 1'b1; tick();
        checks++; if (bus.count !== 7'd0 || bus.upd !== 1'b0) begin errors++; $display("FAIL fill_clr count=%0d upd=%b exp 0 0", bus.count, bus.upd); end
        bus.clr = 1'b0; tick();
        repeat (20) pulse_e();
        checks++; if (bus.count !== 7'd20 || bus.full !== 1'b1 || bus.free !== 7'd0) begin errors++; $display("FAIL fill_full count=%0d full=%b free=%0d exp 20 1 0", bus.count, bus.full, bus.free); end
        checks++; if (bus.bcd_tens !== 4'd2 || bus.bcd_units !== 4'd0) begin errors++; $display("FAIL fill_bcd got %0d/%0d exp 2/0", bus.bcd_tens, bus.bcd_units); end
    endtask

    task automatic test_simultaneous();
        bus.E = 1'b1; bus.S = 1'b1; tick();
        checks++; if (bus.count !== 7'd20 || bus.upd !== 1'b0) begin errors++; $display("FAIL simul_count count=%0d upd=%b exp 20 0", bus.count, bus.upd); end
        checks++; if (bus.err_over !== 1'b0 || bus.err_under !== 1'b0) begin errors++; $display("FAIL simul_err ov=%b un=%b exp 0 0", bus.err_over, bus.err_under); end
        bus.E = 1'b0; bus.S = 1'b0; tick();
    endtask

    task automatic test_overflow();
        bus.E = 1'b1; tick();
        checks++; if (bus.count !== 7'd20 || bus.err_over !== 1'b1 || bus.upd !== 1'b0) begin errors++; $display("FAIL over_sat count=%0d ov=%b upd=%b exp 20 1 0", bus.count, bus.err_over, bus.upd); end
        bus.E = 1'b0; tick();
        pulse_s();
        checks++; if (bus.count !== 7'd19 || bus.full !== 1'b0 || bus.free !== 7'd1) begin errors++; $display("FAIL over_exit count=%0d full=%b free=%0d exp 19 0 1", bus.count, bus.full, bus.free); end
        checks++; if (bus.err_over !== 1'b1) begin errors++; $display("FAIL over_sticky got %b exp 1", bus.err_over); end
    endtask

    task automatic test_held();
        base = upd_cnt;
        bus.E = 1'b1;
        repeat (5) tick();
        bus.E = 1'b0; tick();
        checks++; if (bus.count !== 7'd20) begin errors++; $display("FAIL held_count got %0d exp 20", bus.count); end
        checks++; if (upd_cnt - base !== 1) begin errors++; $display("FAIL held_upd got %0d exp 1", upd_cnt - base); end
    endtask

    task automatic test_underflow();
        do_clr();
        checks++; if (bus.err_over !== 1'b0 || bus.count !== 7'd0) begin errors++; $display("FAIL under_clr ov=%b count=%0d exp 0 0", bus.err_over, bus.count); end
        // An entry edge coinciding with clr is discarded.
        bus.clr = 1'b1; bus.E = 1'b1; tick();
        bus.clr = 1'b0; tick();
        bus.E = 1'b0; tick();
        checks++; if (bus.count !== 7'd0) begin errors++; $display("FAIL clr_discard got %0d exp 0", bus.count); end
        bus.S = 1'b1; tick();
        checks++; if (bus.count !== 7'd0 || bus.err_under !== 1'b1 || bus.upd !== 1'b0) begin errors++; $display("FAIL under_sat count=%0d un=%b upd=%b exp 0 1 0", bus.count, bus.err_under, bus.upd); end
        bus.S = 1'b0; tick();
        do_clr();
        checks++; if (bus.err_under !== 1'b0) begin errors++; $display("FAIL under_clr_flag got %b exp 0", bus.err_under); end
    endtask

    task automatic test_async_reset();
        repeat (12) pulse_e();
        checks++; if (bus.count !== 7'd12 || bus.bcd_tens !== 4'd1 || bus.bcd_units !== 4'd2) begin errors++; $display("FAIL ares_pre count=%0d bcd=%0d/%0d exp 12 1/2", bus.count, bus.bcd_tens, bus.bcd_units); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.count !== 7'd0 || bus.free !== 7'd20 || bus.empty !== 1'b1) begin errors++; $display("FAIL ares_now count=%0d free=%0d empty=%b exp 0 20 1", bus.count, bus.free, bus.empty); end
        checks++; if (bus.bcd_tens !== 4'd0 || bus.bcd_units !== 4'd0 || bus.full !== 1'b0) begin errors++; $display("FAIL ares_bcd got %0d/%0d full=%b exp 0/0 0", bus.bcd_tens, bus.bcd_units, bus.full); end
        // E already high when reset releases counts once at the first edge.
        bus.E = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++; if (bus.count !== 7'd1 || bus.upd !== 1'b1) begin errors++; $display("FAIL ares_release count=%0d upd=%b exp 1 1", bus.count, bus.upd); end
        tick();
        checks++; if (bus.count !== 7'd1) begin errors++; $display("FAIL ares_held got %0d exp 1", bus.count); end
        bus.E = 1'b0; tick();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        upd_cnt = 0;
        base    = 0;
        test_reset();
        test_basic();
        test_bcd_carry();
        test_fill();
        test_simultaneous();
        test_overflow();
        test_held();
        test_underflow();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_counter.md
# parking_counter

Occupancy counter for the parking-lot access controller. Consumes the one-cycle entry (`E`) and exit (`S`) pulses produced by the direction-detection FSM and maintains the number of cars inside, in binary and as two BCD digits for the display stage. Also provides full/empty flags, a free-space count and sticky over/underflow error flags. Sits directly downstream of the direction FSM and upstream of the 7-segment driver and barrier logic.

## Interface
- `CAPACITY`, default 20: lot capacity; legal range 1..99.
- `CW`, default 7: width of binary count outputs; must hold 99.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous reset, active-low (all state cleared while low).
- `E` in 1: entry pulse from direction FSM.
- `S` in 1: exit pulse from direction FSM.
- `clr` in 1: synchronous clear of count and error flags.
- `count` out CW: cars inside, binary.
- `free` out CW: `CAPACITY - count`.
- `bcd_tens` out 4: tens digit of `count`.
- `bcd_units` out 4: units digit of `count`.
- `full` out 1: `count == CAPACITY`.
- `empty` out 1: `count == 0`.
- `upd` out 1: one-cycle strobe, high the cycle after `count` changed.
- `err_over` out 1: sticky; entry attempted while full.
- `err_under` out 1: sticky; exit attempted while empty.

## Operation
- Rising-edge detect on `E` and `S`: registers `e_d`/`s_d` hold the previous sample; event = input high AND previous sample low. An input held high for N cycles counts once.
- Per clock, priority order: `clr` > simultaneous events > single event.
  - `clr`=1: count, BCD digits, `err_over`, `err_under` go to 0; pending edges in that cycle are discarded; `upd` not asserted.
  - Entry and exit edge in the same cycle: net zero, count unchanged, no error flag set, `upd` not asserted, regardless of full/empty.
  - Entry only: if count < CAPACITY, increment, else hold and set `err_over`.
  - Exit only: if count > 0, decrement, else hold and set `err_under`.
- BCD digits are kept as their own registers, updated in lockstep with the binary count (units 9→0 carries into tens on increment; units 0→9 borrows from tens on decrement). No binary-to-BCD divider. Invariant: `10*bcd_tens + bcd_units == count` at all times.
- `full`, `empty` and `free` are decoded from the registered count only, with no combinational path from `E`/`S`/`clr` to any output.
- Error flags remain set until `clr` or reset; counting continues normally while they are set.
- `upd` asserts exactly when the count actually changes (increment or decrement), never on a saturated or cancelled event.

## Timing
- Reset (`rst` low): count=0, bcd=0/0, `free`=CAPACITY, `full`=0, `empty`=1, `upd`=0, errors=0, `e_d`=`s_d`=0.
- Because `e_d`/`s_d` reset to 0, an `E` or `S` held high at reset release is counted once, at the first rising clock edge.
- Latency: an edge sampled at clock edge n updates `count`, BCD, flags and `free` at edge n. All are valid from cycle n+1. `upd` is high during cycle n+1 only.
- Back-to-back one-cycle pulses separated by one low cycle are each counted. A continuously high input is not.
- Assertion of `rst` mid-operation clears state immediately, independent of `clk`.

## Test plan
- **Reset and basic count:** reset, then 3 single-cycle `E` pulses. Expect count=3, bcd 0/3, `free`=17, `empty`=0, and 3 `upd` strobes each one cycle after its pulse.
- **BCD carry/borrow:** count to 9, one `E`. Expect bcd 1/0 and count=10. One `S` gives bcd 0/9. Check the BCD invariant every cycle across the random sequence.
- **Full saturation:** 20 entries (`full`=1, `free`=0), then a 21st `E`. Expect count stays 20, `err_over`=1, no `upd`. Then one `S` gives count=19, `full`=0, and `err_over` still 1.
- **Empty underflow:** `S` from reset. Expect count=0, `err_under`=1, no `upd`. Then `clr` clears the error flag.
- **Simultaneous and held inputs:** `E` and `S` rising in the same cycle at count=20. Expect count=20, no error, no `upd`. Then `E` held high 5 cycles gives a single increment.
- **Async reset mid-run:** at count=12, pulse `rst` low between clock edges. Expect outputs return to reset values immediately.
